reservation_station: RTL and testbench
======================================

Name: reservation_station

Overview:
- Tomasulo-style issue back end fed by the fetch stage: accepts one decoded instruction per cycle into per-class reservation-station slots.
- Tracks register renaming tags and holds the architectural register file.
- Executes add/mul/mv/lw/sw and broadcasts results on one common data bus (CDB).
- The instruction cache (instcache) is a separate block and is outside this spec.

Parameters:
- WORD_SIZE, 32, data/immediate width.
- REG_SIZE, 6, register index width (64 registers).
- UNIT_SIZE, 8, tag width.
- SLOTS, 2, slots per unit class (max 16).
- MUL_LAT, 3, multiply latency in cycles.
- DMEM_AW, 8, data-memory word address width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- unit  in  3  class: 000 lw, 001 sw, 010 add, 011 mul, 100 mv; 101–111 illegal.
- reg1  in  REG_SIZE  destination (sw: store-data source).
- reg2  in  REG_SIZE  first source (lw/sw: base address).
- reg3  in  REG_SIZE  second source when hasimm=0.
- hasimm  in  1  use imm instead of reg3 (mv: instead of reg2).
- imm  in  WORD_SIZE  signed, already sign-extended immediate.
- enable  in  1  dispatch request.
- out  out  1  combinational accept.
- regread  in  1  register-status read strobe.
- regin  in  REG_SIZE  register to query.
- regout  out  UNIT_SIZE  pending tag; 8'h7F = value ready.
- regoutrf  out  WORD_SIZE  signed register value; valid when regout==8'h7F.

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is synchronous, active-low.
- Reset: all slots invalid; all register tags = 8'h7F; register file = 0; pipelines empty. out forced 0 while rst_n=0. Data memory is not reset.
- Accept:
  - out = rst_n & enable & legal unit & free slot exists in that class.
  - Combinational, same cycle; the fetch stage samples it immediately.
  - On the rising edge with out=1, the lowest-index free slot of the class is allocated.
- Tag encoding: tag = {1'b0, class[2:0], slot[3:0]}. Never equals 8'h7F.
- Operand capture at dispatch:
  - A source whose register tag is 7F copies its value.
  - Otherwise the slot stores the producer tag and waits.
  - Sources per class: add/mul reg2 and (imm | reg3); mv (imm | reg2); lw reg2 and imm/reg3 offset; sw reg1 data, reg2 base, imm/reg3 offset.
- Destination rename: for add/mul/mv/lw, the register status of reg1 is set to the new tag on allocation. sw renames nothing.
- regread/regin/regout/regoutrf: combinational lookup of regin. regread only qualifies the read; outputs are valid regardless.
- Issue:
  - A slot issues when all operands are ready.
  - One issue per class per cycle; oldest slot (lowest allocation order) wins.
  - lw/sw share one in-order queue: a memory op issues only after all older memory ops have issued.
- Execution latencies: add, mv = 1 cycle; mul = MUL_LAT cycles (pipelined); lw = 2 cycles; sw writes memory at issue+1 and produces no CDB result.
- Address: (base + offset) truncated to DMEM_AW bits.
- Arithmetic: add/mul produce the low WORD_SIZE bits of the two's-complement result.
- CDB:
  - One broadcast per cycle. Arbitration priority: lw > mul > add > mv.
  - A stalled result holds its unit; the unit does not issue again until the result drains.
- On broadcast:
  - Every waiting operand with a matching tag captures the value.
  - The register file writes the value; the register tag resets to 7F only if it still equals the broadcast tag (WAW safe).
  - The slot is freed the cycle after its broadcast; sw frees its slot after the memory write.
- Same-edge dispatch and broadcast: the dispatched slot captures the broadcast value if its source tag matches.
- Reset mid-operation discards all in-flight work.

Optional Feature:
- Macro: RS_BYPASS_EN.
- Defined: regout/regoutrf forward the current-cycle CDB result when regin's tag matches the broadcast tag (regout reads 7F, regoutrf = CDB value).
- Undefined: the register-file state is visible only from the next cycle.

Decomposition:
- Package rs_pkg: class codes, READY_TAG = 8'h7F, slot record typedef (valid, op, Vj/Vk/Vs, Qj/Qk/Qs, dest, age).
- One natural sub-module, rs_cdb_arbiter (priority select of the ready results).

Test Plan:
- Reset, then regread regin=5 → regout=8'h7F, regoutrf=0.
- mv r1,#7 then add r2,r1,#3 back-to-back → r2 tag pending; after completion regoutrf(r2)=10, regout=7F.
- mul r3,r2,r2 (r2=10) → r3=100 after MUL_LAT+1 cycles. Dispatching a third mul with 2 mul slots busy → out=0.
- sw r2,[r0+#4] then lw r4,[r0+#4] → r4=10; lw does not issue before sw.
- WAW: mul r5,… then mv r5,#1 → final r5=1; the late mul broadcast leaves r5's tag at 7F.
- Assert rst_n=0 with slots busy → next cycle out follows free slots, all tags 7F.

Source files
------------

// File: rtl/rs_pkg.sv
// rtl/rs_pkg.sv - Shared widths, class codes, tag constants and slot record for the reservation station.
package rs_pkg;

  localparam int WORD_SIZE = 32;
  localparam int REG_SIZE  = 6;
  localparam int UNIT_SIZE = 8;
  localparam int AGE_W     = 8;
  localparam int NCLS      = 5;

  localparam logic [UNIT_SIZE-1:0] READY_TAG = 8'h7F;

  typedef enum logic [2:0] {
    U_LW  = 3'd0,
    U_SW  = 3'd1,
    U_ADD = 3'd2,
    U_MUL = 3'd3,
    U_MV  = 3'd4
  } unit_e;

  // j/k are the two computation operands; s is the store-data operand (sw only)
  typedef struct packed {
    logic                 valid;
    logic                 issued;
    unit_e                op;
    logic [WORD_SIZE-1:0] vj;
    logic [WORD_SIZE-1:0] vk;
    logic [WORD_SIZE-1:0] vs;
    logic [UNIT_SIZE-1:0] qj;
    logic [UNIT_SIZE-1:0] qk;
    logic [UNIT_SIZE-1:0] qs;
    logic [REG_SIZE-1:0]  dest;
    logic [AGE_W-1:0]     age;
  } slot_t;

  function automatic logic [UNIT_SIZE-1:0] make_tag(input logic [2:0] cls, input logic [3:0] slot);
    return {1'b0, cls, slot};
  endfunction

  // Wrap-safe age compare; far fewer ops are in flight than half the age range
  function automatic logic older(input logic [AGE_W-1:0] a, input logic [AGE_W-1:0] b);
    logic [AGE_W-1:0] d;
    d = a - b;
    return d[AGE_W-1];
  endfunction

  function automatic logic is_mem(input unit_e op);
    return (op == U_LW) || (op == U_SW);
  endfunction

endpackage

// File: rtl/reservation_station_if.sv
// rtl/reservation_station_if.sv - Dispatch handshake and register-status lookup bundle.
interface reservation_station_if;
  import rs_pkg::*;

  logic [2:0]                  unit;
  logic [REG_SIZE-1:0]         reg1;
  logic [REG_SIZE-1:0]         reg2;
  logic [REG_SIZE-1:0]         reg3;
  logic                        hasimm;
  logic [WORD_SIZE-1:0]        imm;
  logic                        enable;
  logic                        out;
  logic                        regread;
  logic [REG_SIZE-1:0]         regin;
  logic [UNIT_SIZE-1:0]        regout;
  logic signed [WORD_SIZE-1:0] regoutrf;

  modport master (
    output unit, reg1, reg2, reg3, hasimm, imm, enable, regread, regin,
    input  out, regout, regoutrf
  );

  modport slave (
    input  unit, reg1, reg2, reg3, hasimm, imm, enable, regread, regin,
    output out, regout, regoutrf
  );

endinterface

// File: rtl/rs_cdb_arbiter.sv
// rtl/rs_cdb_arbiter.sv - Fixed-priority select of one result for the common data bus.
module rs_cdb_arbiter
  import rs_pkg::*;
#(
  parameter int IW = 4
) (
  input  logic [3:0]                req,
  input  logic [3:0][UNIT_SIZE-1:0] tag,
  input  logic [3:0][WORD_SIZE-1:0] data,
  input  logic [3:0][IW-1:0]        idx,
  output logic [3:0]                gnt,
  output logic                      cdb_valid,
  output logic [UNIT_SIZE-1:0]      cdb_tag,
  output logic [WORD_SIZE-1:0]      cdb_data,
  output logic [IW-1:0]             cdb_idx
);

  // Requester 0 (lw) has highest priority, then mul, add, mv
  always_comb begin
    gnt       = '0;
    cdb_valid = 1'b0;
    cdb_tag   = READY_TAG;
    cdb_data  = '0;
    cdb_idx   = '0;
    for (int i = 3; i >= 0; i--) begin
      if (req[i]) begin
        gnt       = '0;
        gnt[i]    = 1'b1;
        cdb_valid = 1'b1;
        cdb_tag   = tag[i];
        cdb_data  = data[i];
        cdb_idx   = idx[i];
      end
    end
  end

endmodule

// File: rtl/reservation_station.sv
// rtl/reservation_station.sv - Tomasulo back end: dispatch, rename, issue, execute and CDB writeback.
// RS_BYPASS_EN forwards the live CDB result onto the register-status lookup.
module reservation_station
  import rs_pkg::*;
#(
  parameter int SLOTS   = 2,
  parameter int MUL_LAT = 3,
  parameter int DMEM_AW = 8
) (
  input logic clk,
  input logic rst_n,
  reservation_station_if.slave bus
);
  localparam int NS   = NCLS * SLOTS;
  localparam int IW   = $clog2(NS);
  localparam int NREG = 2 ** REG_SIZE;

  slot_t                slots [NS];
  logic [UNIT_SIZE-1:0] tags [NREG];
  logic [WORD_SIZE-1:0] rf [NREG];
  logic [WORD_SIZE-1:0] dmem [2**DMEM_AW];
  logic [AGE_W-1:0]     age_ctr;

  logic                 add_v, mv_v, lw1_v, lw2_v, sw_v;
  logic [UNIT_SIZE-1:0] add_tag, mv_tag, lw1_tag, lw2_tag;
  logic [IW-1:0]        add_idx, mv_idx, lw1_idx, lw2_idx, sw_idx;
  logic [WORD_SIZE-1:0] add_d, mv_d, lw2_d, sw_d;
  logic [DMEM_AW-1:0]   lw1_a, sw_a;
  logic [MUL_LAT-1:0]   mul_v;
  logic [UNIT_SIZE-1:0] mul_tag [MUL_LAT];
  logic [IW-1:0]        mul_idx [MUL_LAT];
  logic [WORD_SIZE-1:0] mul_d [MUL_LAT];

  logic [3:0]           gnt;
  logic                 cdb_valid;
  logic [UNIT_SIZE-1:0] cdb_tag;
  logic [WORD_SIZE-1:0] cdb_data;
  logic [IW-1:0]        cdb_idx;

  rs_cdb_arbiter #(.IW(IW)) u_arb (
    .req      ({mv_v, add_v, mul_v[MUL_LAT-1], lw2_v}),
    .tag      ({mv_tag, add_tag, mul_tag[MUL_LAT-1], lw2_tag}),
    .data     ({mv_d, add_d, mul_d[MUL_LAT-1], lw2_d}),
    .idx      ({mv_idx, add_idx, mul_idx[MUL_LAT-1], lw2_idx}),
    .gnt      (gnt),
    .cdb_valid(cdb_valid),
    .cdb_tag  (cdb_tag),
    .cdb_data (cdb_data),
    .cdb_idx  (cdb_idx)
  );

  // A unit may issue only if its output stage drains this cycle or is empty
  logic mul_adv, lw1_adv, lw2_adv;
  logic [NCLS-1:0] unit_free;
  assign mul_adv   = !mul_v[MUL_LAT-1] || gnt[1];
  assign lw2_adv   = !lw2_v || gnt[0];
  assign lw1_adv   = !lw1_v || lw2_adv;
  assign unit_free = {!mv_v || gnt[3], mul_adv, !add_v || gnt[2], 1'b1, lw1_adv};

  logic            legal, have_free;
  logic [2:0]      cls;
  logic [IW-1:0]   free_idx;
  logic [3:0]      free_slot;
  assign legal   = bus.unit <= 3'd4;
  assign cls     = legal ? bus.unit : 3'd0;
  assign bus.out = rst_n && bus.enable && legal && have_free;

  always_comb begin
    have_free = 1'b0;
    free_idx  = '0;
    free_slot = '0;
    for (int s = SLOTS - 1; s >= 0; s--) begin
      if (!slots[int'(cls) * SLOTS + s].valid) begin
        have_free = 1'b1;
        free_idx  = IW'(int'(cls) * SLOTS + s);
        free_slot = 4'(s);
      end
    end
  end

  // Operand capture at dispatch, including a result broadcast on this same edge
  logic [REG_SIZE-1:0]  sreg [3];
  logic [UNIT_SIZE-1:0] nq [3];
  logic [WORD_SIZE-1:0] nv [3];
  always_comb begin
    sreg[0] = bus.reg2;
    sreg[1] = bus.reg3;
    sreg[2] = bus.reg1;
    for (int i = 0; i < 3; i++) begin
      nq[i] = tags[sreg[i]];
      nv[i] = rf[sreg[i]];
      if (cdb_valid && nq[i] == cdb_tag) begin
        nq[i] = READY_TAG;
        nv[i] = cdb_data;
      end
    end
    if (cls == U_MV && bus.hasimm) begin
      nq[0] = READY_TAG;
      nv[0] = bus.imm;
    end
    if (cls == U_MV) begin
      nq[1] = READY_TAG;
      nv[1] = '0;
    end else if (bus.hasimm) begin
      nq[1] = READY_TAG;
      nv[1] = bus.imm;
    end
    if (cls != U_SW) begin
      nq[2] = READY_TAG;
      nv[2] = '0;
    end
  end

  logic                 rdy [NS];
  logic [NCLS-1:0]      iss_v;
  logic [IW-1:0]        iss_idx [NCLS];
  logic [UNIT_SIZE-1:0] iss_tag [NCLS];
  logic [WORD_SIZE-1:0] iss_j [NCLS];
  logic [WORD_SIZE-1:0] iss_k [NCLS];
  logic [WORD_SIZE-1:0] iss_s [NCLS];
  always_comb begin
    for (int i = 0; i < NS; i++) begin
      rdy[i] = slots[i].valid && !slots[i].issued && slots[i].qj == READY_TAG &&
               slots[i].qk == READY_TAG && slots[i].qs == READY_TAG;
      // lw and sw form one in-order stream
      if (is_mem(slots[i].op)) begin
        for (int j = 0; j < NS; j++) begin
          if (slots[j].valid && !slots[j].issued && is_mem(slots[j].op) &&
              older(slots[j].age, slots[i].age))
            rdy[i] = 1'b0;
        end
      end
    end
    for (int c = 0; c < NCLS; c++) begin
      iss_v[c]   = 1'b0;
      iss_idx[c] = '0;
      iss_tag[c] = READY_TAG;
      for (int s = 0; s < SLOTS; s++) begin
        if (rdy[c * SLOTS + s] &&
            (!iss_v[c] || older(slots[c * SLOTS + s].age, slots[iss_idx[c]].age))) begin
          iss_v[c]   = 1'b1;
          iss_idx[c] = IW'(c * SLOTS + s);
          iss_tag[c] = make_tag(3'(c), 4'(s));
        end
      end
      iss_v[c] = iss_v[c] && unit_free[c];
      iss_j[c] = slots[iss_idx[c]].vj;
      iss_k[c] = slots[iss_idx[c]].vk;
      iss_s[c] = slots[iss_idx[c]].vs;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NS; i++) slots[i] <= '0;
      for (int r = 0; r < NREG; r++) begin
        tags[r] <= READY_TAG;
        rf[r]   <= '0;
      end
      add_v   <= 1'b0;
      mv_v    <= 1'b0;
      lw1_v   <= 1'b0;
      lw2_v   <= 1'b0;
      sw_v    <= 1'b0;
      mul_v   <= '0;
      age_ctr <= '0;
    end else begin
      if (cdb_valid) begin
        for (int i = 0; i < NS; i++) begin
          if (slots[i].qj == cdb_tag) begin slots[i].qj <= READY_TAG; slots[i].vj <= cdb_data; end
          if (slots[i].qk == cdb_tag) begin slots[i].qk <= READY_TAG; slots[i].vk <= cdb_data; end
          if (slots[i].qs == cdb_tag) begin slots[i].qs <= READY_TAG; slots[i].vs <= cdb_data; end
        end
        slots[cdb_idx].valid <= 1'b0;
        // A newer rename of the destination owns the register; drop the stale result
        if (tags[slots[cdb_idx].dest] == cdb_tag) begin
          tags[slots[cdb_idx].dest] <= READY_TAG;
          rf[slots[cdb_idx].dest]   <= cdb_data;
        end
      end

      for (int c = 0; c < NCLS; c++) begin
        if (iss_v[c]) slots[iss_idx[c]].issued <= 1'b1;
      end

      sw_v   <= iss_v[U_SW];
      sw_idx <= iss_idx[U_SW];
      sw_a   <= DMEM_AW'(iss_j[U_SW] + iss_k[U_SW]);
      sw_d   <= iss_s[U_SW];
      if (sw_v) slots[sw_idx].valid <= 1'b0;

      if (iss_v[U_ADD]) begin
        add_v <= 1'b1; add_tag <= iss_tag[U_ADD]; add_idx <= iss_idx[U_ADD];
        add_d <= iss_j[U_ADD] + iss_k[U_ADD];
      end else if (gnt[2]) add_v <= 1'b0;

      if (iss_v[U_MV]) begin
        mv_v <= 1'b1; mv_tag <= iss_tag[U_MV]; mv_idx <= iss_idx[U_MV]; mv_d <= iss_j[U_MV];
      end else if (gnt[3]) mv_v <= 1'b0;

      if (mul_adv) begin
        mul_v[0]   <= iss_v[U_MUL];
        mul_tag[0] <= iss_tag[U_MUL];
        mul_idx[0] <= iss_idx[U_MUL];
        mul_d[0]   <= iss_j[U_MUL] * iss_k[U_MUL];
        for (int s = 1; s < MUL_LAT; s++) begin
          mul_v[s]   <= mul_v[s-1];
          mul_tag[s] <= mul_tag[s-1];
          mul_idx[s] <= mul_idx[s-1];
          mul_d[s]   <= mul_d[s-1];
        end
      end

      if (lw2_adv) begin
        lw2_v <= lw1_v; lw2_tag <= lw1_tag; lw2_idx <= lw1_idx; lw2_d <= dmem[lw1_a];
      end
      if (lw1_adv) begin
        lw1_v <= iss_v[U_LW]; lw1_tag <= iss_tag[U_LW]; lw1_idx <= iss_idx[U_LW];
        lw1_a <= DMEM_AW'(iss_j[U_LW] + iss_k[U_LW]);
      end

      // Dispatch comes last so a rename on this edge overrides a broadcast clear
      if (bus.out) begin
        slots[free_idx] <= '{valid: 1'b1, issued: 1'b0, op: unit_e'(cls),
                             vj: nv[0], vk: nv[1], vs: nv[2], qj: nq[0], qk: nq[1], qs: nq[2],
                             dest: bus.reg1, age: age_ctr};
        if (cls != U_SW) tags[bus.reg1] <= make_tag(cls, free_slot);
        age_ctr <= age_ctr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && sw_v) dmem[sw_a] <= sw_d;
  end

  always_comb begin
    bus.regout   = tags[bus.regin];
    bus.regoutrf = rf[bus.regin];
`ifdef RS_BYPASS_EN
    if (cdb_valid && tags[bus.regin] == cdb_tag) begin
      bus.regout   = READY_TAG;
      bus.regoutrf = cdb_data;
    end
`else
`endif
  end

endmodule

// File: tb/tb_reservation_station.sv
// tb/tb_reservation_station.sv - Scoreboard bench: directed dispatches and register-status queries.
module tb_reservation_station;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  reservation_station_if bus ();
  reservation_station dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  localparam logic [2:0] LW = 3'd0, SW = 3'd1, ADD = 3'd2, MUL = 3'd3, MV = 3'd4;
  localparam logic [7:0] RDY = 8'h7F;

  typedef struct { logic want; string name; } out_exp_t;
  typedef struct { logic [7:0] tag; logic [31:0] val; string name; } rd_exp_t;

  out_exp_t out_q[$];
  rd_exp_t  rd_q[$];
  out_exp_t oe;
  rd_exp_t  re;
  int checks = 0;
  int errors = 0;

  always @(negedge clk) begin
    if (bus.enable) begin
      checks++;
      if (out_q.size() == 0) begin
        errors++;
        $display("FAIL out_unexpected: out=%0b with no expectation queued", bus.out);
      end else begin
        oe = out_q.pop_front();
        if (bus.out !== oe.want) begin
          errors++;
          $display("FAIL %s: out=%0b expected %0b", oe.name, bus.out, oe.want);
        end
      end
    end
    if (bus.regread) begin
      checks++;
      if (rd_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: regout=%h with no expectation queued", bus.regout);
      end else begin
        re = rd_q.pop_front();
        if (bus.regout !== re.tag || bus.regoutrf !== re.val) begin
          errors++;
          $display("FAIL %s: regout=%h regoutrf=%h expected regout=%h regoutrf=%h",
                   re.name, bus.regout, bus.regoutrf, re.tag, re.val);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic dispatch(input logic [2:0] u, input int r1, input int r2, input int r3,
                          input logic hi, input logic [31:0] im, input logic want, input string nm);
    bus.unit   = u;
    bus.reg1   = 6'(r1);
    bus.reg2   = 6'(r2);
    bus.reg3   = 6'(r3);
    bus.hasimm = hi;
    bus.imm    = im;
    bus.enable = 1'b1;
    out_q.push_back('{want: want, name: nm});
    @(posedge clk);
    #1;
    bus.enable = 1'b0;
  endtask

  task automatic query(input int r, input logic [7:0] tag, input logic [31:0] val, input string nm);
    bus.regin   = 6'(r);
    bus.regread = 1'b1;
    rd_q.push_back('{tag: tag, val: val, name: nm});
    @(posedge clk);
    #1;
    bus.regread = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.unit = '0; bus.reg1 = '0; bus.reg2 = '0; bus.reg3 = '0;
    bus.hasimm = 1'b0; bus.imm = '0; bus.enable = 1'b0; bus.regread = 1'b0; bus.regin = '0;
    idle(2);
    dispatch(ADD, 1, 2, 3, 1'b0, 0, 1'b0, "out_in_reset");
    rst_n = 1'b1;
    query(5, RDY, 0, "reset_r5");
    dispatch(3'd5, 1, 0, 0, 1'b1, 0, 1'b0, "illegal_unit");

    // mv r1,#7 ; add r2,r1,#3
    dispatch(MV, 1, 0, 0, 1'b1, 7, 1'b1, "mv_r1");
    dispatch(ADD, 2, 1, 0, 1'b1, 3, 1'b1, "add_r2");
    query(2, 8'h20, 0, "r2_pending");
    idle(5);
    query(2, RDY, 10, "r2_done");
    query(1, RDY, 7, "r1_done");

    // mul r3,r2,r2: broadcast lands MUL_LAT+1 cycles after dispatch
    dispatch(MUL, 3, 2, 2, 1'b0, 0, 1'b1, "mul_r3");
    idle(3);
    query(3, 8'h30, 0, "r3_in_flight");
    query(3, RDY, 100, "r3_done");

    // Two mul slots busy: third mul refused
    dispatch(MUL, 6, 2, 0, 1'b1, 2, 1'b1, "mul_r6");
    dispatch(MUL, 7, 2, 0, 1'b1, -3, 1'b1, "mul_r7");
    dispatch(MUL, 8, 2, 0, 1'b1, 5, 1'b0, "mul_full");
    idle(6);
    query(6, RDY, 20, "r6_done");
    query(7, RDY, 32'hFFFF_FFE2, "r7_negative");
    query(8, RDY, 0, "r8_untouched");

    // Memory order: mem[4]=7 first, then a stalled sw of 50 ahead of lw
    dispatch(SW, 1, 0, 0, 1'b1, 4, 1'b1, "sw_r1");
    idle(4);
    dispatch(MUL, 9, 2, 0, 1'b1, 5, 1'b1, "mul_r9");
    dispatch(SW, 9, 0, 0, 1'b1, 4, 1'b1, "sw_r9");
    dispatch(LW, 4, 0, 0, 1'b1, 4, 1'b1, "lw_r4");
    query(4, 8'h00, 0, "r4_pending");
    idle(10);
    query(4, RDY, 50, "lw_after_sw");
    query(9, RDY, 50, "r9_done");

    // WAW: late mul result must not overwrite r5
    dispatch(MUL, 5, 2, 0, 1'b1, 3, 1'b1, "mul_r5");
    dispatch(MV, 5, 0, 0, 1'b1, 1, 1'b1, "mv_r5");
    query(5, 8'h40, 0, "r5_renamed");
    idle(6);
    query(5, RDY, 1, "waw_r5");

    // Dispatch on the same edge as the producer broadcast
    dispatch(MUL, 11, 2, 0, 1'b1, 2, 1'b1, "mul_r11");
    idle(3);
    dispatch(ADD, 12, 11, 0, 1'b1, 1, 1'b1, "add_r12");
    idle(4);
    query(12, RDY, 21, "same_edge_r12");

    // Reset with both mul slots occupied
    dispatch(MUL, 13, 2, 0, 1'b1, 1, 1'b1, "mul_r13");
    dispatch(MUL, 14, 2, 0, 1'b1, 1, 1'b1, "mul_r14");
    rst_n = 1'b0;
    dispatch(MUL, 15, 2, 0, 1'b1, 1, 1'b0, "out_during_reset");
    rst_n = 1'b1;
    dispatch(MUL, 15, 2, 0, 1'b1, 1, 1'b1, "out_after_reset");
    query(15, 8'h30, 0, "r15_slot0");
    query(13, RDY, 0, "r13_cleared");
    query(2, RDY, 0, "r2_cleared");
    idle(6);

    checks++;
    if (out_q.size() != 0 || rd_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: out_q=%0d rd_q=%0d expected 0 0", out_q.size(), rd_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
